// File: rtl/muldiv_if.sv
// Operand/result bundle between the issue stage and the multiply/divide unit.
// The master side issues operations; the slave side (the unit) returns HI/LO and status.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi_write, lo_write, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi_write, lo_write, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with a one-cycle write pulse.
// Optional MULDIV_DIV0_FAST_EN: a divide by zero completes with multiply latency.
module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_reg, state_next, issue_state;
  logic [1:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] quo_reg, dvs_reg, rem_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [CW-1:0] cnt_reg;
  logic        neg_q_reg, neg_r_reg;

  logic        accept, signed_div, div0;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] rem_shift;
  logic        rem_fits;

  assign accept     = bus.start && !bus.flush && (state_reg == IDLE || state_reg == DONE);
  assign signed_div = !bus.op[0];
  assign div0       = (b_reg == 32'd0);

  // Sign-extend only for MULT; the low 64 bits of the wide product are exact either way.
  assign ext_a   = {{32{!op_reg[0] & a_reg[31]}}, a_reg};
  assign ext_b   = {{32{!op_reg[0] & b_reg[31]}}, b_reg};
  assign product = ext_a * ext_b;

  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_fits  = rem_shift >= {1'b0, dvs_reg};

`ifdef MULDIV_DIV0_FAST_EN
  assign issue_state = (bus.op[1] && bus.b != 32'd0) ? DIV : MUL;
`else
  assign issue_state = bus.op[1] ? DIV : MUL;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = issue_state;
        MUL:     state_next = DONE;
        DIV:     if (cnt_reg == CW'(DIV_ITERS - 1)) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = bus.start ? issue_state : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (accept) begin
      op_reg    <= bus.op;
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      quo_reg   <= (signed_div && bus.a[31]) ? -bus.a : bus.a;
      dvs_reg   <= (signed_div && bus.b[31]) ? -bus.b : bus.b;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= signed_div && (bus.a[31] ^ bus.b[31]);
      neg_r_reg <= signed_div && bus.a[31];
    end else begin
      case (state_reg)
        MUL: if (!bus.flush) begin
          // A divide only lands here when the fast divide-by-zero path is built in.
          if (op_reg[1]) begin
            hi_reg <= a_reg;
            lo_reg <= 32'hFFFF_FFFF;
          end else begin
            hi_reg <= product[63:32];
            lo_reg <= product[31:0];
          end
        end
        DIV: begin
          rem_reg <= rem_fits ? (rem_shift[31:0] - dvs_reg) : rem_shift[31:0];
          quo_reg <= {quo_reg[30:0], rem_fits};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: if (!bus.flush) begin
          if (div0) begin
            hi_reg <= a_reg;
            lo_reg <= 32'hFFFF_FFFF;
          end else begin
            hi_reg <= neg_r_reg ? -rem_reg : rem_reg;
            lo_reg <= neg_q_reg ? -quo_reg : quo_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = accept || state_reg == MUL || state_reg == DIV || state_reg == FIX;
  assign bus.done     = (state_reg == DONE);
  assign bus.hi_write = bus.done;
  assign bus.lo_write = bus.done;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU and produces the HI/LO pair with a one-cycle write pulse to the HI/LO forwarding and writeback path.
- Drives `busy`, which the hazard unit ORs into the global stall while an operation is in flight.

Parameters:
- DIV_ITERS, 32, restoring-divide iterations; one quotient bit per cycle; must equal the operand width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request a new operation; sampled each cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  rs operand (multiplicand / dividend)
- b  input  32  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation (exception / pipeline flush)
- busy  output  1  stall request to the hazard unit
- done  output  1  one-cycle pulse; `hi`/`lo` are valid this cycle
- hi_write  output  1  equals `done`
- lo_write  output  1  equals `done`
- hi  output  32  product[63:32] or remainder
- lo  output  32  product[31:0] or quotient

Behaviour:
- **Reset:** every register is cleared asynchronously. State = IDLE; `busy`, `done`, `hi_write`, `lo_write` = 0; `hi` = `lo` = 0.
- **States:** IDLE, MUL, DIV, FIX, DONE.
- **Accept:**
  - `start` is accepted only in IDLE or DONE, and only when `flush` = 0.
  - On accept, `a`, `b` and `op` are latched.
  - `start` in MUL, DIV or FIX is ignored.
- **busy:** `busy` = (`start` & state ∈ {IDLE, DONE} & !`flush`) | state ∈ {MUL, DIV, FIX}. It is combinational on `start` so the stall asserts in the same cycle as issue. `busy` = 0 in DONE.
- **Multiply path (op[1] = 0):**
  - Accept → MUL.
  - In MUL, the 64-bit product is registered. MULT is signed × signed; MULTU is unsigned.
  - MUL → DONE.
  - If `start` is seen in cycle N, `done` = 1 in cycle N+2.
- **Divide path (op[1] = 1):**
  - Accept → DIV. The iteration counter is cleared.
  - DIVU uses the raw operands. DIV uses |a| and |b|, and records neg_q = a[31]^b[31] and neg_r = a[31].
  - DIV runs exactly DIV_ITERS cycles of restoring shift/subtract on a 33-bit partial remainder. When the counter reaches DIV_ITERS-1, go to FIX.
  - FIX: negate the quotient if neg_q; negate the remainder if neg_r. Then → DONE.
  - If `start` is seen in cycle N, `done` = 1 in cycle N+DIV_ITERS+2 (N+34).
- **Divide by zero (b = 0):**
  - Result is fixed for both signed and unsigned: `lo` = 32'hFFFFFFFF, `hi` = `a`.
  - Timing is the normal divide latency unless the optional feature is enabled.
- **Signed overflow:** 32'h80000000 / 32'hFFFFFFFF (DIV) gives `lo` = 32'h80000000, `hi` = 0. Two's-complement wrap, no trap.
- **DONE:**
  - `done`, `hi_write`, `lo_write` = 1 for exactly one cycle.
  - Next state is IDLE, or MUL/DIV if a new `start` is accepted in that cycle (back-to-back issue).
- **hi/lo hold:** `hi`/`lo` update only on entry to DONE and hold their value otherwise.
- **Flush:**
  - `flush` = 1 in any state → IDLE next cycle.
  - No `done` pulse is produced; `hi`/`lo` keep their previous value.
  - `flush` has priority over `start` and over DONE.
- **Reset mid-operation:** immediate return to IDLE with all outputs zero.

Optional Feature:
- Macro: MULDIV_DIV0_FAST_EN.
- **Defined:** a divide whose latched `b` = 0 skips DIV/FIX and goes straight to DONE with `lo` = 32'hFFFFFFFF, `hi` = `a`. `done` is at N+2, the same latency as multiply.
- **Undefined:** divide-by-zero takes the full N+34 latency with the same result values.

Test Plan:
- MULT a=32'hFFFFFFFE (-2), b=3 → `done` at N+2; `hi` = 32'hFFFFFFFF, `lo` = 32'hFFFFFFFA; `busy` = 1 in cycles N and N+1 only.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF → `hi` = 32'hFFFFFFFE, `lo` = 32'h00000001.
- DIV a=-7 (32'hFFFFFFF9), b=2 → `done` at N+34; `lo` = 32'hFFFFFFFD, `hi` = 32'hFFFFFFFF. Then DIVU 100/7 → `lo` = 14, `hi` = 2.
- DIV 32'h80000000 / 32'hFFFFFFFF → `lo` = 32'h80000000, `hi` = 0. DIVU 5/0 → `lo` = 32'hFFFFFFFF, `hi` = 5, with `done` at N+34 (N+2 with MULDIV_DIV0_FAST_EN).
- Start DIVU 100/7, assert `flush` at N+10 → IDLE at N+11, `busy` = 0, no `done`, `hi`/`lo` unchanged. Also assert `start` during DIV → ignored.
- Back-to-back: MULT 2×3, then `start` MULTU 4×5 in its DONE cycle → `done` pulses at N+2 (`lo` = 6) and N+4 (`lo` = 20). Async `reset` mid-DIV → outputs 0 immediately.
